// File: rtl/frame_pkg.sv
`default_nettype none
// ============================================================================
// Module   : frame_pkg
// Brief    : Shared frame geometry constants and object-table types.
// Revision : 1.0 - initial release
// ============================================================================
package frame_pkg;

    localparam int COOR_WIDTH = 12;
    localparam int FRAME_W    = 1280;
    localparam int FRAME_H    = 300;
    localparam int NUM_OBJ    = 8;
    localparam int IDX_WIDTH  = 3;

    typedef logic [1:0] palette_t;

    typedef struct packed {
        logic [COOR_WIDTH-1:0] x;
        logic [COOR_WIDTH-1:0] y;
        logic [COOR_WIDTH-1:0] w;
        logic [COOR_WIDTH-1:0] h;
        palette_t              palette;
    } obj_t;

    localparam obj_t OBJ_DISABLED = '0;

endpackage
`default_nettype wire

// File: rtl/renderer_hit_test.sv
`default_nettype none
// ============================================================================
// Module   : renderer_hit_test
// Brief    : Tests whether a pixel lies inside one object rectangle.
// Revision : 1.0 - initial release
// ============================================================================
module renderer_hit_test
    import frame_pkg::*;
(
    input  obj_t                  obj,
    input  logic [COOR_WIDTH-1:0] x,
    input  logic [COOR_WIDTH-1:0] y,
    output logic                  hit
);

    logic [COOR_WIDTH:0] x_end;
    logic [COOR_WIDTH:0] y_end;

    // One extra bit keeps far-edge sums from wrapping back to column/row 0.
    assign x_end = {1'b0, obj.x} + {1'b0, obj.w};
    assign y_end = {1'b0, obj.y} + {1'b0, obj.h};

    assign hit = (obj.palette != 2'd0)
               && (x >= obj.x) && ({1'b0, x} < x_end)
               && (y >= obj.y) && ({1'b0, y} < y_end);

endmodule
`default_nettype wire

// File: rtl/frame_renderer.sv
`default_nettype none
// ============================================================================
// Module   : frame_renderer
// Brief    : Raster-scans the frame window once per buffer swap and emits the
//            per-pixel palette of the top-priority covering rectangle.
//            FRAME_RENDERER_OVERRUN_CNT_EN adds the overrun_count output.
// Revision : 1.0 - initial release
// ============================================================================
module frame_renderer #(
    parameter int COOR_WIDTH = frame_pkg::COOR_WIDTH,
    parameter int FRAME_W    = frame_pkg::FRAME_W,
    parameter int FRAME_H    = frame_pkg::FRAME_H,
    parameter int NUM_OBJ    = frame_pkg::NUM_OBJ,
    parameter int IDX_WIDTH  = frame_pkg::IDX_WIDTH
) (
    input  logic                  clk_33m,
    input  logic                  rst_n,
    input  logic                  rst_screen_33m,
    input  logic [1:0]            bg_palette,
    input  logic                  obj_wr_en,
    input  logic [IDX_WIDTH-1:0]  obj_wr_idx,
    input  logic [COOR_WIDTH-1:0] obj_x,
    input  logic [COOR_WIDTH-1:0] obj_y,
    input  logic [COOR_WIDTH-1:0] obj_w,
    input  logic [COOR_WIDTH-1:0] obj_h,
    input  logic [1:0]            obj_palette,
    output logic [COOR_WIDTH-1:0] write_x,
    output logic [COOR_WIDTH-1:0] write_y,
    output logic [1:0]            write_palette,
    output logic                  frame_busy,
    output logic                  frame_overrun
`ifdef FRAME_RENDERER_OVERRUN_CNT_EN
    ,
    output logic [15:0]           overrun_count
`endif
);

    import frame_pkg::*;

    localparam logic [COOR_WIDTH-1:0] X_LAST = COOR_WIDTH'(FRAME_W - 1);
    localparam logic [COOR_WIDTH-1:0] Y_LAST = COOR_WIDTH'(FRAME_H - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  rst_screen_q;
    logic                  start;
    logic                  in_scan;
    logic                  overrun;
    logic                  last_pix;

    logic [COOR_WIDTH-1:0] x_q, x_d, y_q, y_d;
    obj_t                  shadow_q [NUM_OBJ];
    obj_t                  shadow_d [NUM_OBJ];
    obj_t                  active_q [NUM_OBJ];
    obj_t                  active_d [NUM_OBJ];
    palette_t              bg_q, bg_d;

    logic [NUM_OBJ-1:0]    hit;
    logic [NUM_OBJ-1:0]    hit_q, hit_d;
    logic [COOR_WIDTH-1:0] x2_q, x2_d, y2_q, y2_d;
    logic                  v2_q, v2_d;

    palette_t              sel_pal;
    logic [COOR_WIDTH-1:0] write_x_q, write_x_d, write_y_q, write_y_d;
    palette_t              write_pal_q, write_pal_d;
    logic                  overrun_q, overrun_d;

    always_comb begin
        start    = rst_screen_33m & ~rst_screen_q;
        in_scan  = (state_q == ST_SCAN);
        overrun  = start & in_scan;
        last_pix = (x_q == X_LAST) && (y_q == Y_LAST);
    end

    // Stage 1: scan FSM and pixel counter
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SCAN;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            ST_SCAN: begin
                if (start) begin
                    x_d = '0;
                    y_d = '0;
                end else if (last_pix) begin
                    state_d = ST_DONE;
                end else if (x_q == X_LAST) begin
                    x_d = '0;
                    y_d = y_q + 1'b1;
                end else begin
                    x_d = x_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_d = ST_SCAN;
                    x_d     = '0;
                    y_d     = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Active table takes the shadow contents from before any same-cycle write.
    always_comb begin
        for (int i = 0; i < NUM_OBJ; i++) begin
            shadow_d[i] = shadow_q[i];
            active_d[i] = start ? shadow_q[i] : active_q[i];
        end
        if (obj_wr_en && (int'(obj_wr_idx) < NUM_OBJ)) begin
            shadow_d[obj_wr_idx] = '{x: obj_x, y: obj_y, w: obj_w, h: obj_h,
                                     palette: obj_palette};
        end
        bg_d = start ? bg_palette : bg_q;
    end

    // Stage 2: per-slot hit test
    for (genvar g = 0; g < NUM_OBJ; g++) begin : g_hit
        renderer_hit_test u_hit (
            .obj (active_q[g]),
            .x   (x_q),
            .y   (y_q),
            .hit (hit[g])
        );
    end

    always_comb begin
        hit_d = hit;
        x2_d  = x_q;
        y2_d  = y_q;
        v2_d  = in_scan & ~start;
    end

    // Stage 3: priority select, highest index wins
    always_comb begin
        sel_pal = bg_q;
        for (int i = 0; i < NUM_OBJ; i++) begin
            if (hit_q[i]) begin
                sel_pal = active_q[i].palette;
            end
        end
        write_pal_d = (v2_q && !overrun) ? sel_pal : 2'd0;
        write_x_d   = x2_q;
        write_y_d   = y2_q;
        overrun_d   = overrun_q | overrun;
    end

    always_ff @(posedge clk_33m) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            rst_screen_q <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            bg_q         <= 2'd0;
            hit_q        <= '0;
            x2_q         <= '0;
            y2_q         <= '0;
            v2_q         <= 1'b0;
            write_x_q    <= '0;
            write_y_q    <= '0;
            write_pal_q  <= 2'd0;
            overrun_q    <= 1'b0;
            for (int i = 0; i < NUM_OBJ; i++) begin
                shadow_q[i] <= OBJ_DISABLED;
                active_q[i] <= OBJ_DISABLED;
            end
        end else begin
            state_q      <= state_d;
            rst_screen_q <= rst_screen_33m;
            x_q          <= x_d;
            y_q          <= y_d;
            bg_q         <= bg_d;
            hit_q        <= hit_d;
            x2_q         <= x2_d;
            y2_q         <= y2_d;
            v2_q         <= v2_d;
            write_x_q    <= write_x_d;
            write_y_q    <= write_y_d;
            write_pal_q  <= write_pal_d;
            overrun_q    <= overrun_d;
            for (int i = 0; i < NUM_OBJ; i++) begin
                shadow_q[i] <= shadow_d[i];
                active_q[i] <= active_d[i];
            end
        end
    end

`ifdef FRAME_RENDERER_OVERRUN_CNT_EN
    logic [15:0] ovr_cnt_q, ovr_cnt_d;

    always_comb begin
        ovr_cnt_d = ovr_cnt_q;
        if (overrun && (ovr_cnt_q != 16'hFFFF)) begin
            ovr_cnt_d = ovr_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_33m) begin
        if (!rst_n) begin
            ovr_cnt_q <= 16'd0;
        end else begin
            ovr_cnt_q <= ovr_cnt_d;
        end
    end

    assign overrun_count = ovr_cnt_q;
`endif

    // The frame store ignores writes during the swap strobe, so suppress them here too.
    assign write_palette = rst_screen_33m ? 2'd0 : write_pal_q;
    assign write_x       = write_x_q;
    assign write_y       = write_y_q;
    assign frame_busy    = in_scan;
    assign frame_overrun = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_renderer.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_renderer
// Brief    : Self-checking bench for frame_renderer on a reduced 32x24 window.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frame_renderer;

    localparam int W    = 32;
    localparam int H    = 24;
    localparam int NPIX = W * H;
    localparam int NOBJ = 8;

    logic        clk_33m = 1'b0;
    logic        rst_n = 1'b0;
    logic        rst_screen_33m = 1'b0;
    logic [1:0]  bg_palette = 2'd0;
    logic        obj_wr_en = 1'b0;
    logic [2:0]  obj_wr_idx = 3'd0;
    logic [11:0] obj_x = '0, obj_y = '0, obj_w = '0, obj_h = '0;
    logic [1:0]  obj_palette = 2'd0;
    logic [11:0] write_x, write_y;
    logic [1:0]  write_palette;
    logic        frame_busy, frame_overrun;
`ifdef FRAME_RENDERER_OVERRUN_CNT_EN
    logic [15:0] overrun_count;
`endif

    always #5 clk_33m = ~clk_33m;

    frame_renderer #(.FRAME_W(W), .FRAME_H(H)) dut (
        .clk_33m        (clk_33m),
        .rst_n          (rst_n),
        .rst_screen_33m (rst_screen_33m),
        .bg_palette     (bg_palette),
        .obj_wr_en      (obj_wr_en),
        .obj_wr_idx     (obj_wr_idx),
        .obj_x          (obj_x),
        .obj_y          (obj_y),
        .obj_w          (obj_w),
        .obj_h          (obj_h),
        .obj_palette    (obj_palette),
        .write_x        (write_x),
        .write_y        (write_y),
        .write_palette  (write_palette),
        .frame_busy     (frame_busy),
        .frame_overrun  (frame_overrun)
`ifdef FRAME_RENDERER_OVERRUN_CNT_EN
        ,
        .overrun_count  (overrun_count)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: object tables as plain integer rectangles
    typedef struct { int x; int y; int w; int h; int pal; } rect_t;
    rect_t shadow_m [NOBJ];
    rect_t active_m [NOBJ];
    int    bg_m = 0;
    bit    strobe_prev = 1'b0;

    typedef struct { int x; int y; int pal; } wr_t;
    wr_t got [$];
    int  cyc = 0;
    int  first_wr_cyc = -1;
    int  last_wr_cyc = -1;
    int  busy_cycles = 0;
    int  start_cyc = 0;

    always @(negedge clk_33m) begin
        cyc++;
        if (frame_busy === 1'b1) busy_cycles++;
        if (write_palette !== 2'd0) begin
            if (first_wr_cyc < 0) first_wr_cyc = cyc;
            last_wr_cyc = cyc;
            got.push_back('{x: int'(write_x), y: int'(write_y), pal: int'(write_palette)});
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic int expect_pix(input int x, input int y);
        int p;
        p = bg_m;
        for (int i = 0; i < NOBJ; i++) begin
            if (active_m[i].pal != 0 && x >= active_m[i].x && x < active_m[i].x + active_m[i].w
                && y >= active_m[i].y && y < active_m[i].y + active_m[i].h)
                p = active_m[i].pal;
        end
        return p;
    endfunction

    function automatic int got_pal(input int k);
        return (k < got.size()) ? got[k].pal : -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_pix(input string tag, input int k, input int gx, gy, gp, ex, ey, ep);
        checks++;
        assert (gx === ex && gy === ey && gp === ep) else begin
            errors++;
            $error("FAIL %s[%0d]: observed (%0d,%0d,pal%0d) expected (%0d,%0d,pal%0d)",
                   tag, k, gx, gy, gp, ex, ey, ep);
        end
    endtask

    // One clock; the model absorbs the inputs the DUT sampled on this edge.
    task automatic tick();
        @(posedge clk_33m);
        if (!rst_n) begin
            for (int i = 0; i < NOBJ; i++) begin
                shadow_m[i] = '{0, 0, 0, 0, 0};
                active_m[i] = '{0, 0, 0, 0, 0};
            end
            strobe_prev = 1'b0;
        end else begin
            if (rst_screen_33m && !strobe_prev) begin
                active_m = shadow_m;
                bg_m     = int'(bg_palette);
            end
            strobe_prev = rst_screen_33m;
            if (obj_wr_en && int'(obj_wr_idx) < NOBJ)
                shadow_m[obj_wr_idx] = '{int'(obj_x), int'(obj_y), int'(obj_w), int'(obj_h),
                                         int'(obj_palette)};
        end
        #1;
    endtask

    task automatic write_obj(input int idx, x, y, w, h, pal);
        obj_wr_en   = 1'b1;
        obj_wr_idx  = 3'(idx);
        obj_x       = 12'(x);
        obj_y       = 12'(y);
        obj_w       = 12'(w);
        obj_h       = 12'(h);
        obj_palette = 2'(pal);
        tick();
        obj_wr_en   = 1'b0;
    endtask

    task automatic start_frame(input int hold, input int bg);
        bg_palette     = 2'(bg);
        rst_screen_33m = 1'b1;
        @(negedge clk_33m);
        #1;
        got.delete();
        first_wr_cyc = -1;
        last_wr_cyc  = -1;
        busy_cycles  = 0;
        start_cyc    = cyc;
        for (int i = 0; i < hold; i++) tick();
        rst_screen_33m = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (frame_busy !== 1'b0 && n < NPIX + 50) begin
            tick();
            n++;
        end
        check({tag, "_done"}, 32'(n < NPIX + 50), 32'd1);
        repeat (4) tick();
    endtask

    task automatic check_frame(input string tag, input int skip);
        int k;
        k = 0;
        for (int p = skip; p < NPIX; p++) begin
            int e;
            e = expect_pix(p % W, p / W);
            if (e != 0) begin
                if (k < got.size())
                    check_pix(tag, k, got[k].x, got[k].y, got[k].pal, p % W, p / W, e);
                k++;
            end
        end
        check({tag, "_count"}, got.size(), k);
    endtask

    initial begin
        int h;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("rst_wpal", write_palette, 0);
        check("rst_wx", write_x, 0);
        check("rst_wy", write_y, 0);
        check("rst_busy", frame_busy, 0);
        check("rst_ovr", frame_overrun, 0);
`ifdef FRAME_RENDERER_OVERRUN_CNT_EN
        check("rst_ocnt", overrun_count, 0);
`endif

        // Empty table, background 1
        start_frame(1, 1);
        wait_idle("t1");
        check_frame("t1", 0);
        check("t1_n", got.size(), NPIX);
        check("t1_first_lat", first_wr_cyc - start_cyc, 3);
        check("t1_last_lat", last_wr_cyc - start_cyc, NPIX + 2);
        check("t1_busy_cycles", busy_cycles, NPIX);
        if (got.size() > 0) begin
            check("t1_last_x", got[got.size()-1].x, W - 1);
            check("t1_last_y", got[got.size()-1].y, H - 1);
        end
        check("t1_busy_end", frame_busy, 0);
        check("t1_ovr", frame_overrun, 0);

        // Overlapping rectangles: slot 7 beats slot 0
        write_obj(0, 10, 20, 4, 2, 2);
        write_obj(7, 12, 20, 4, 2, 3);
        start_frame(1, 1);
        wait_idle("t2");
        check_frame("t2", 0);
        check("t2_p10_20", got_pal(20 * W + 10), 2);
        check("t2_p11_21", got_pal(21 * W + 11), 2);
        check("t2_p12_20", got_pal(20 * W + 12), 3);
        check("t2_p15_21", got_pal(21 * W + 15), 3);
        check("t2_p16_20", got_pal(20 * W + 16), 1);
        check("t2_p10_22", got_pal(22 * W + 10), 1);

        // Rectangle hanging past the bottom-right corner
        write_obj(0, 0, 0, 0, 0, 0);
        write_obj(7, 0, 0, 0, 0, 0);
        write_obj(1, W - 2, H - 2, 10, 10, 2);
        start_frame(1, 0);
        wait_idle("t3");
        check_frame("t3", 0);
        check("t3_n", got.size(), 4);

        // Shadow write mid-scan, then a write coinciding with the start edge
        start_frame(1, 0);
        repeat (100) tick();
        write_obj(3, 2, 2, 3, 3, 1);
        wait_idle("t4a");
        check_frame("t4a", 0);
        check("t4a_n", got.size(), 4);
        obj_wr_en = 1'b1; obj_wr_idx = 3'd4;
        obj_x = 12'd20; obj_y = 12'd5; obj_w = 12'd2; obj_h = 12'd2; obj_palette = 2'd3;
        start_frame(1, 0);
        obj_wr_en = 1'b0;
        wait_idle("t4b");
        check_frame("t4b", 0);
        check("t4b_n", got.size(), 13);
        start_frame(1, 0);
        wait_idle("t4c");
        check_frame("t4c", 0);
        check("t4c_n", got.size(), 17);

        // Overrun: second start edge part-way through the scan
        start_frame(1, 2);
        repeat (300) tick();
        check("t5_ovr_before", frame_overrun, 0);
        start_frame(1, 2);
        check("t5_ovr", frame_overrun, 1);
`ifdef FRAME_RENDERER_OVERRUN_CNT_EN
        check("t5_ocnt", overrun_count, 1);
`endif
        wait_idle("t5");
        check_frame("t5", 0);
        check("t5_first_lat", first_wr_cyc - start_cyc, 3);
        check("t5_busy_cycles", busy_cycles, NPIX);
        check("t5_ovr_sticky", frame_overrun, 1);

        // Reset in the middle of a scan
        start_frame(1, 1);
        repeat (50) tick();
        rst_n = 1'b0;
        tick();
        check("t6_rst_wpal", write_palette, 0);
        check("t6_rst_wx", write_x, 0);
        check("t6_rst_wy", write_y, 0);
        check("t6_rst_busy", frame_busy, 0);
        check("t6_rst_ovr", frame_overrun, 0);
`ifdef FRAME_RENDERER_OVERRUN_CNT_EN
        check("t6_rst_ocnt", overrun_count, 0);
`endif
        rst_n = 1'b1;
        tick();

        // Strobe held high for 5 cycles: one start, first two pixels dropped
        start_frame(5, 1);
        wait_idle("t6");
        check_frame("t6", 2);
        check("t6_n", got.size(), NPIX - 2);
        check("t6_ovr", frame_overrun, 0);
        check("t6_busy_cycles", busy_cycles, NPIX);

        // Randomized tables, strobe lengths and mid-scan writes
        for (int f = 0; f < 6; f++) begin
            for (int n = 0; n < 4; n++)
                write_obj($urandom_range(0, 7), $urandom_range(0, W + 3), $urandom_range(0, H + 3),
                          $urandom_range(0, 12), $urandom_range(0, 8), $urandom_range(0, 3));
            h = $urandom_range(1, 5);
            start_frame(h, $urandom_range(0, 3));
            repeat ($urandom_range(1, NPIX / 2)) tick();
            write_obj($urandom_range(0, 7), $urandom_range(0, W), $urandom_range(0, H),
                      $urandom_range(1, 12), $urandom_range(1, 8), $urandom_range(1, 3));
            wait_idle("rnd");
            check_frame("rnd", (h > 3) ? h - 3 : 0);
        end
        check("rnd_ovr", frame_overrun, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
